axi_lite_regbank: RTL and testbench



---
 rtl/axi_lite_regbank.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_lite_regbank.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank.
// Write path: independent AW/W holding registers feeding a W_IDLE/W_COMMIT/W_RESP FSM.
// Read path: R_IDLE/R_RESP FSM. Each read response is registered on the AR handshake edge.
// RO registers return the live status_in slice. Their storage keeps RESET_VAL.
module axi_lite_regbank #(
    parameter int unsigned          DATA_W       = 32,
    parameter int unsigned          REG_NUM      = 8,
    parameter int unsigned          ADDR_W       = 32,
    parameter logic [REG_NUM-1:0]   RO_MASK      = '0,
    parameter logic [DATA_W-1:0]    RESET_VAL    = '0,
    parameter logic [DATA_W-1:0]    INVALID_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           awaddr,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W/8-1:0]         wstrb,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [ADDR_W-1:0]           araddr,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [DATA_W-1:0]           rdata,
    output logic [1:0]                  rresp,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [REG_NUM*DATA_W-1:0]   reg_out,
    input  logic [REG_NUM*DATA_W-1:0]   status_in,
    output logic [REG_NUM-1:0]          wr_pulse
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_RESP}           r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [DATA_W-1:0] regs [REG_NUM];

    logic              ready_en;
    logic              aw_held, w_held;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;

    logic              aw_hs, w_hs, ar_hs, b_hs, r_hs, commit;
    logic [IDX_W-1:0]  ar_idx;
    logic [REG_NUM-1:0] aw_sel, ar_sel;
    logic              aw_ok;
    logic [DATA_W-1:0] rd_value;
    logic [1:0]        rd_resp;
    logic              unused_bits;

    // Byte-offset bits are ignored by design.
    // status_in slices of RW registers are never read.
    assign unused_bits = ^{awaddr[OFF_W-1:0], araddr[OFF_W-1:0], status_in};

    assign ar_idx = araddr[ADDR_W-1:OFF_W];
    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign b_hs   = bvalid && bready;
    assign r_hs   = rvalid && rready;
    assign aw_ok  = |(aw_sel & ~RO_MASK);

    // Ready outputs stay low through reset and rise on the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ready_en <= 1'b0;
        else     ready_en <= 1'b1;
    end

    // Address decode: one-hot select of the held write index and the live read index.
    always_comb begin
        aw_sel = '0;
        ar_sel = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            aw_sel[i] = (aw_idx_q == IDX_W'(i));
            ar_sel[i] = (ar_idx == IDX_W'(i));
        end
    end

    // AW and W holding registers.
    // Each register is loaded on its own handshake and released on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held  <= 1'b0;
            aw_idx_q <= '0;
            w_held   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                aw_idx_q <= awaddr[ADDR_W-1:OFF_W];
            end else if (commit) begin
                aw_held  <= 1'b0;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= wdata;
                w_strb_q <= wstrb;
            end else if (commit) begin
                w_held   <= 1'b0;
            end
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write FSM next state.
    // The second payload's handshake counts as held, so the FSM enters W_COMMIT on that same edge.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (b_hs) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs.
    always_comb begin
        commit  = (w_state == W_COMMIT);
        bvalid  = (w_state == W_RESP);
        awready = ready_en && !aw_held && !bvalid;
        wready  = ready_en && !w_held && !bvalid;
    end

    // Register storage, write response and per-register write strobe.
    // Only RW registers are ever written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) regs[i] <= RESET_VAL;
            bresp    <= RESP_OKAY;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                bresp    <= aw_ok ? RESP_OKAY : RESP_SLVERR;
                wr_pulse <= aw_sel & ~RO_MASK;
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    if (aw_sel[i] && !RO_MASK[i]) begin
                        for (int unsigned b = 0; b < STRB_W; b++) begin
                            if (w_strb_q[b]) regs[i][8*b +: 8] <= w_data_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read data selection for the index presented on araddr.
    always_comb begin
        rd_value = INVALID_DATA;
        rd_resp  = RESP_SLVERR;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            if (ar_sel[i]) begin
                rd_resp  = RESP_OKAY;
                rd_value = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs[i];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read FSM next state.
    always_comb begin
        r_next = r_state;
        if (r_state == R_IDLE) begin
            if (ar_hs) r_next = R_RESP;
        end else begin
            if (r_hs)  r_next = R_IDLE;
        end
    end

    // Read FSM outputs.
    always_comb begin
        arready = ready_en && (r_state == R_IDLE);
        rvalid  = (r_state == R_RESP);
    end

    // Read response capture on the AR handshake edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            rresp <= RESP_OKAY;
        end else if (ar_hs) begin
            rdata <= rd_value;
            rresp <= rd_resp;
        end
    end

    // Flattened view of storage.
    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < REG_NUM; i++) reg_out[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Self-checking bench for axi_lite_regbank.
// The configuration uses DATA_W=32, REG_NUM=8 and RO_MASK=8'h80.
// The reference model is a word array updated byte-by-byte from the register-bank rules.
module tb_axi_lite_regbank;

    localparam int          DW  = 32;
    localparam int          RN  = 8;
    localparam int          AW  = 32;
    localparam logic [7:0]  RO  = 8'h80;
    localparam logic [31:0] RV  = 32'h5A5A_0001;
    localparam logic [31:0] INV = 32'hDEAD_BEEF;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  awaddr;
    logic           awvalid;
    logic           awready;
    logic [DW-1:0]  wdata;
    logic [3:0]     wstrb;
    logic           wvalid;
    logic           wready;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [AW-1:0]  araddr;
    logic           arvalid;
    logic           arready;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;
    logic [RN*DW-1:0] reg_out;
    logic [RN*DW-1:0] status_in;
    logic [RN-1:0]  wr_pulse;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [RN];
    int          exp_pulse [RN];
    int          pulse_cnt [RN];
    int          bvalid_cycles = 0;

    axi_lite_regbank #(
        .DATA_W    (DW),
        .REG_NUM   (RN),
        .ADDR_W    (AW),
        .RO_MASK   (RO),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .reg_out   (reg_out),
        .status_in (status_in),
        .wr_pulse  (wr_pulse)
    );

    always #5 clk = ~clk;

    // Count strobe cycles and bvalid cycles away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < RN; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
        if (bvalid === 1'b1) bvalid_cycles++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < RN; i++) model[i] = RV;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp);
        int unsigned idx;
        idx = addr / 4;
        resp = 2'b10;
        if (idx < RN) begin
            if (!RO[idx]) begin
                for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                exp_pulse[idx]++;
                resp = 2'b00;
            end
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
        int unsigned idx;
        idx = addr / 4;
        d = INV;
        resp = 2'b10;
        if (idx < RN) begin
            resp = 2'b00;
            d = RO[idx] ? status_in[idx*32 +: 32] : model[idx];
        end
    endtask

    // Drive AW after aw_lag cycles and W after w_lag cycles.
    // lat is the number of cycles from the later handshake edge to the first bvalid.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input int aw_lag, input int w_lag,
                             output logic [1:0] resp, output int lat, output bit held_ready);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int t = 0;
        resp = 2'bxx;
        held_ready = 0;
        awaddr = addr;
        wdata = d;
        wstrb = s;
        while (!(aw_done && w_done) && t < 40) begin
            awvalid = !aw_done && (t >= aw_lag);
            wvalid  = !w_done && (t >= w_lag);
            if ((aw_done && awready) || (w_done && wready)) held_ready = 1;
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_now) aw_done = 1;
            if (w_now)  w_done = 1;
            t++;
        end
        awvalid = 0;
        wvalid = 0;
        lat = 0;
        while (bvalid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bvalid === 1'b1) begin
            resp = bresp;
            @(posedge clk); #1;
        end else begin
            lat = -1;
        end
    endtask

    // Read one word. rvalid must be high right after the handshake edge, otherwise d is forced to x.
    task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
        bit done = 0, now;
        int t = 0;
        araddr = addr;
        while (!done && t < 40) begin
            arvalid = 1;
            now = arready;
            @(posedge clk); #1;
            if (now) done = 1;
            t++;
        end
        arvalid = 0;
        d = 'x;
        resp = 'x;
        if (done && rvalid === 1'b1) begin
            d = rdata;
            resp = rresp;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] d,
                            input logic [3:0] s, input int aw_lag, input int w_lag);
        logic [1:0] er, r;
        int lat;
        bit hr;
        model_write(addr, d, s, er);
        axi_write(addr, d, s, aw_lag, w_lag, r, lat, hr);
        check({tag, " bresp"}, r, er);
        check({tag, " b_latency"}, lat, 1);
        check({tag, " ready_while_held"}, hr, 0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr);
        logic [31:0] ed, d;
        logic [1:0] er, r;
        model_read(addr, ed, er);
        axi_read(addr, d, r);
        check({tag, " rdata"}, d, ed);
        check({tag, " rresp"}, r, er);
    endtask

    task automatic check_pulses(input string tag);
        for (int i = 0; i < RN; i++) check($sformatf("%s wr_pulse[%0d] count", tag, i), pulse_cnt[i], exp_pulse[i]);
    endtask

    task automatic check_reg_out(input string tag);
        for (int i = 0; i < RN; i++) check($sformatf("%s reg_out[%0d]", tag, i), reg_out[i*32 +: 32], model[i]);
    endtask

    initial begin
        logic [31:0] old_val, new_val, rd_snap;
        logic [1:0]  er;
        bit          hs_a, hs_b;
        int          b0;

        rst = 1; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 1; araddr = '0; arvalid = 0; rready = 1;
        status_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        status_in[7*32 +: 32] = 32'hCAFE_F00D;
        model_reset();

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        check("rst awready", awready, 0);
        check("rst wready", wready, 0);
        check("rst arready", arready, 0);
        check("rst bvalid", bvalid, 0);
        check("rst rvalid", rvalid, 0);
        check("rst rdata", rdata, 0);
        check("rst bresp", bresp, 0);
        check("rst wr_pulse", wr_pulse, 0);
        check_reg_out("rst");
        rst = 0;
        #1;
        check("post_rst awready before edge", awready, 0);
        @(posedge clk); #1;
        check("post_rst awready", awready, 1);
        check("post_rst wready", wready, 1);
        check("post_rst arready", arready, 1);

        // Fill and read back the RW registers.
        for (int i = 0; i < 7; i++) do_write($sformatf("fill%0d", i), 32'(4*i), 32'hA5A5_0000 + 32'(i), 4'hF, 0, 0);
        for (int i = 0; i < 7; i++) do_read($sformatf("fill_rd%0d", i), 32'(4*i));
        check_pulses("fill");
        check_reg_out("fill");

        // W presented three cycles ahead of AW.
        do_write("w_first", 32'h8, 32'h1234_5678, 4'hF, 3, 0);
        do_read("w_first_rd", 32'h8);
        // AW presented two cycles ahead of W.
        do_write("aw_first", 32'h14, 32'h0BAD_CAFE, 4'hF, 0, 2);
        do_read("aw_first_rd", 32'h14);
        check_pulses("order");

        // Partial byte strobes and an all-zero strobe.
        do_write("strb_all", 32'h4, 32'hFFFF_FFFF, 4'hF, 0, 0);
        do_write("strb_0101", 32'h4, 32'h0000_0000, 4'b0101, 0, 0);
        do_read("strb_rd", 32'h4);
        check("strb_0101 model", model[1], 32'hFF00_FF00);
        do_write("strb_none", 32'h10, 32'h1357_9BDF, 4'h0, 1, 0);
        do_read("strb_none_rd", 32'h10);
        check_pulses("strb");

        // RO and out-of-range accesses, plus a read with ignored byte-offset bits.
        do_write("ro_wr", 32'h1C, 32'h1111_1111, 4'hF, 0, 0);
        do_write("oob_wr", 32'h40, 32'h2222_2222, 4'hF, 0, 0);
        do_write("oob_hi_wr", 32'h8000_0000, 32'h3333_3333, 4'hF, 0, 1);
        do_read("ro_rd", 32'h1C);
        do_read("oob_rd", 32'h40);
        do_read("offset_rd", 32'h0B);
        check_pulses("err");
        check_reg_out("err");

        // Random mix of reads and writes.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 11) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) do_read($sformatf("rnd_rd%0d", n), a);
            else do_write($sformatf("rnd_wr%0d", n), a, $urandom, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check_pulses("rnd");
        check_reg_out("rnd");

        // The read handshake lands on the commit edge of a write to the same register.
        // Both responses are then held under backpressure.
        bready = 0;
        rready = 0;
        new_val = $urandom;
        awaddr = 32'hC; wdata = new_val; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 32'hC;
        hs_a = awready && wready;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        check("bp aw_w handshake", hs_a, 1);
        check("bp awready in commit", awready, 0);
        arvalid = 1;
        hs_b = arready;
        @(posedge clk); #1;
        arvalid = 0;
        check("bp ar handshake", hs_b, 1);
        old_val = model[3];
        model_write(32'hC, new_val, 4'hF, er);
        check("bp bvalid", bvalid, 1);
        check("bp bresp", bresp, er);
        check("bp rvalid", rvalid, 1);
        check("bp rdata pre-write", rdata, old_val);
        check("bp rresp", rresp, 0);
        rd_snap = rdata;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp hold%0d bvalid", c), bvalid, 1);
            check($sformatf("bp hold%0d rvalid", c), rvalid, 1);
            check($sformatf("bp hold%0d rdata", c), rdata, rd_snap);
            check($sformatf("bp hold%0d awready", c), awready, 0);
            check($sformatf("bp hold%0d wready", c), wready, 0);
        end
        bready = 1;
        rready = 1;
        @(posedge clk); #1;
        check("bp release bvalid", bvalid, 0);
        check("bp release rvalid", rvalid, 0);
        check("bp release awready", awready, 1);
        check("bp release wready", wready, 1);
        check("bp release arready", arready, 1);
        do_read("bp post_rd", 32'hC);
        check_pulses("bp");

        // Reset asserted while the FSM is in W_COMMIT.
        awaddr = 32'h10; wdata = 32'h7777_7777; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        b0 = bvalid_cycles;
        rst = 1;
        #2;
        check("midrst awready", awready, 0);
        check("midrst arready", arready, 0);
        check("midrst bvalid", bvalid, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst no bvalid", bvalid_cycles - b0, 0);
        check("midrst wr_pulse", pulse_cnt[4], exp_pulse[4]);
        model_reset();
        check_reg_out("midrst");
        for (int i = 0; i < 7; i++) do_read($sformatf("midrst_rd%0d", i), 32'(4*i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
